character_buffer_writer: RTL

//  Upstream feeder for the keyboard character buffer register file. Accepts one

---
 rtl/keyboard_pkg.sv | 15 +
 rtl/character_buffer_writer.sv | 118 +++++++++++
 2 files changed

// File: rtl/keyboard_pkg.sv
// Shared widths and buffer-state encodings for the keyboard character path.
package keyboard_pkg;

   localparam int CHAR_W         = 8;
   localparam int CHARS_PER_WORD = 8;
   localparam int WORD_W         = CHAR_W * CHARS_PER_WORD;
   localparam int BUF_ADDR_W     = 5;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      PARTIAL = 2'd1,
      FULL    = 2'd2
   } buf_state_t;

endpackage

// File: rtl/character_buffer_writer.sv
// Packs ASCII chars lowest-byte-first into words for the character register file;
// one write pulse a cycle after each completed/flushed word, input dropped when FULL.
module character_buffer_writer
   import keyboard_pkg::*;
#(
   parameter int ADDR_W = BUF_ADDR_W,
   parameter int CHARS  = CHARS_PER_WORD,
   parameter bit WRAP   = 1'b1
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [CHAR_W-1:0]           char_in,
   input  logic                        char_valid,
   input  logic                        backspace,
   input  logic                        flush,
   input  logic                        clear,
   output logic [CHARS*CHAR_W-1:0]     data_out,
   output logic [ADDR_W-1:0]           address,
   output logic                        write,
   output logic [$clog2(CHARS)-1:0]    char_count,
   output logic [ADDR_W:0]             word_count,
   output logic                        full
);

   localparam int CNT_W = $clog2(CHARS);
   localparam int DW    = CHARS * CHAR_W;
   localparam logic [ADDR_W:0] WC_MAX   = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [CNT_W:0]  FILL_MAX = (CNT_W+1)'(CHARS);

   buf_state_t          state, state_nxt;
   logic [DW-1:0]       pack, pack_nxt, data_nxt, word_v;
   logic [CNT_W-1:0]    cnt_nxt, bs_lane;
   logic [CNT_W:0]      fill;
   logic [ADDR_W-1:0]   ptr, ptr_nxt, addr_nxt;
   logic [ADDR_W:0]     wc_nxt;
   logic                wr_nxt, commit;

   always_comb begin
      state_nxt = state;
      pack_nxt  = pack;
      cnt_nxt   = char_count;
      ptr_nxt   = ptr;
      wc_nxt    = word_count;
      wr_nxt    = 1'b0;
      data_nxt  = data_out;
      addr_nxt  = address;
      word_v    = pack;
      fill      = {1'b0, char_count};
      commit    = 1'b0;
      bs_lane   = char_count - CNT_W'(1);

      if (clear) begin
         state_nxt = EMPTY;
         pack_nxt  = '0;
         cnt_nxt   = '0;
         ptr_nxt   = '0;
         wc_nxt    = '0;
         addr_nxt  = '0;
      end else if (state != FULL) begin
         if (backspace) begin
            // Only the unwritten partial word can be edited; a char in the same cycle is dropped.
            if (state == PARTIAL) begin
               for (int k = 0; k < CHARS; k++)
                  if (CNT_W'(k) == bs_lane) pack_nxt[k*CHAR_W +: CHAR_W] = '0;
               cnt_nxt   = bs_lane;
               state_nxt = (bs_lane == '0) ? EMPTY : PARTIAL;
            end
         end else begin
            if (char_valid) begin
               for (int k = 0; k < CHARS; k++)
                  if (CNT_W'(k) == char_count) word_v[k*CHAR_W +: CHAR_W] = char_in;
               fill = fill + (CNT_W+1)'(1);
            end
            // The char is appended before flush is considered, so an 8th char + flush writes once.
            commit = (fill == FILL_MAX) || (flush && (fill != '0));
            if (commit) begin
               wr_nxt    = 1'b1;
               data_nxt  = word_v;
               addr_nxt  = ptr;
               ptr_nxt   = ptr + ADDR_W'(1);
               wc_nxt    = (word_count == WC_MAX) ? WC_MAX : word_count + (ADDR_W+1)'(1);
               pack_nxt  = '0;
               cnt_nxt   = '0;
               state_nxt = (!WRAP && (wc_nxt == WC_MAX)) ? FULL : EMPTY;
            end else begin
               pack_nxt  = word_v;
               cnt_nxt   = fill[CNT_W-1:0];
               state_nxt = (fill == '0) ? EMPTY : PARTIAL;
            end
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= EMPTY;
         pack       <= '0;
         char_count <= '0;
         ptr        <= '0;
         word_count <= '0;
         write      <= 1'b0;
         data_out   <= '0;
         address    <= '0;
      end else begin
         state      <= state_nxt;
         pack       <= pack_nxt;
         char_count <= cnt_nxt;
         ptr        <= ptr_nxt;
         word_count <= wc_nxt;
         write      <= wr_nxt;
         data_out   <= data_nxt;
         address    <= addr_nxt;
      end
   end

   assign full = (state == FULL);

endmodule
